// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM state
// encoding and the width of the shared adder slice.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

endpackage

// File: rtl/adder_4bits.sv
// 4-bit carry-lookahead adder slice; every carry is formed directly from
// generate/propagate terms rather than rippling.
module adder_4bits
  import adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             ci_i,
  output logic [NIB_W-1:0] s_o,
  output logic             co_o
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s_o  = p ^ c[NIB_W-1:0];
  assign co_o = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one shared 4-bit adder slice, one nibble
// per clock (LS nibble first), with valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] nib_sum_d;
  logic             carry_d;

  adder_4bits u_slice (
    .a_i  (a_q[NIB_W*idx_q +: NIB_W]),
    .b_i  (b_q[NIB_W*idx_q +: NIB_W]),
    .ci_i (c_q),
    .s_o  (nib_sum_d),
    .co_o (carry_d)
  );

  // Subtraction is folded in at capture time: B is stored inverted and the
  // carry seeded with 1, so RUN never needs to know which op it is doing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_sub ? ~in_b : in_b;
            c_q        <= in_sub;
            idx_q      <= '0;
            sum_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q[NIB_W*idx_q +: NIB_W] <= nib_sum_d;
          c_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_co    = c_q;
  // b_q already holds ~B for subtract, so the add-overflow rule covers both ops.
  assign out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed plus randomized bench for nibble_serial_adder_ctrl (WIDTH=16),
// checked against an integer-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned sum gives carry, exact signed result gives overflow.
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
    int unsigned ua, ub, ures;
    int sa, sb, sres;
    logic co, ovf;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (sub) begin
      ures = ua + 32'h10000 - ub;
      sres = sa - sb;
    end else begin
      ures = ua + ub;
      sres = sa + sb;
    end
    co  = (ures >= 32'h10000);
    ovf = (sres > 32767) || (sres < -32768);
    return {ovf, co, ures[15:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. hold = DONE cycles with out_ready low; poke keeps
  // in_valid asserted with junk operands from accept through retirement.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input bit poke);
    logic [17:0]  exp;
    logic [W-1:0] held_sum;
    logic         held_co, held_ovf;
    int n;
    exp = model(a, b, sub);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    cyc();
    in_valid = poke;
    in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready !== 1'b0) chk("busy_in_ready", 32'(in_ready), 32'd0);
      cyc();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    held_sum = out_sum; held_co = out_co; held_ovf = out_ovf;
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_stable", {13'd0, out_ovf, out_co, out_sum},
          {13'd0, held_ovf, held_co, held_sum});
    end
    chk("sum", 32'(out_sum), 32'(exp[15:0]));
    chk("co", 32'(out_co), 32'(exp[16]));
    chk("ovf", 32'(out_ovf), 32'(exp[17]));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("retired_valid", 32'(out_valid), 32'd0);
    chk("retired_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {13'd0, out_ovf, out_co, out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 3, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1, 1, 1'b1);

    // Abort mid-RUN at idx=2, then confirm a clean follow-up result.
    in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_outputs", {13'd0, out_ovf, out_co, out_sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
